// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver FSM encoding, bus register map, defaults.
package spart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DB_LO  = 2'd2;
  localparam logic [1:0] ADDR_DB_HI  = 2'd3;

  localparam int unsigned DEF_OVERSAMPLE = 16;
  localparam int unsigned DEF_DATA_BITS  = 8;

endpackage

// File: rtl/spart_sync2.sv
// Two-flop synchronizer for asynchronous SPART inputs; reset value selectable.
module spart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability filter: two back-to-back flops, both forced to RST_VAL on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spart_receive.sv
// SPART receiver: 8N1 deserializer on a 16x oversample enable with a one-entry
// receive buffer released by a bus read of the data register.
module spart_receive
  import spart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter logic        IDLE_LVL   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 brg_tick,
  input  logic                 rxd,
  input  logic                 iocs,
  input  logic                 iorw,
  input  logic [1:0]           ioaddr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int unsigned   TW        = $clog2(OVERSAMPLE);
  localparam int unsigned   BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t              state, state_n;
  logic [TW-1:0]          tick_cnt, tick_n;
  logic [BW-1:0]          bit_cnt, bit_n;
  logic [DATA_BITS-1:0]   shift, shift_n;
  logic                   rxd_s;
  logic                   line_low;
  logic                   break_hold;
  logic                   complete;
  logic                   rd_data;

  spart_sync2 #(.RST_VAL(IDLE_LVL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  assign line_low = (rxd_s != IDLE_LVL);
  assign rd_data  = iocs & iorw & (ioaddr == ADDR_DATA);
  assign rx_busy  = (state != RX_IDLE);

  // FSM, counters and shift register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RX_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
    end
  end

  // Next-state: start detect is ungated; all sampling waits on brg_tick.
  always_comb begin
    state_n  = state;
    tick_n   = tick_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift;
    complete = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (line_low && !break_hold) begin
          state_n = RX_START;
          tick_n  = '0;
        end
      end
      RX_START: begin
        if (brg_tick) begin
          if (tick_cnt == HALF_LAST) begin
            tick_n = '0;
            bit_n  = '0;
            state_n = line_low ? RX_DATA : RX_IDLE;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (brg_tick) begin
          if (tick_cnt == FULL_LAST) begin
            shift_n = {rxd_s, shift[DATA_BITS-1:1]};
            tick_n  = '0;
            if (bit_cnt == BIT_LAST) state_n = RX_STOP;
            else                     bit_n   = bit_cnt + 1'b1;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (brg_tick) begin
          if (tick_cnt == FULL_LAST) begin
            complete = 1'b1;
            tick_n   = '0;
            state_n  = RX_IDLE;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  // Break lockout: a low stop bit blocks restart until the line is seen idle.
  always_ff @(posedge clk) begin
    if (rst)                       break_hold <= 1'b0;
    else if (complete && line_low) break_hold <= 1'b1;
    else if (!line_low)            break_hold <= 1'b0;
  end

  // Receive buffer and status; completion takes priority over a same-clk read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else if (complete) begin
      rx_data     <= shift;
      framing_err <= line_low;
      overrun     <= overrun | (rda & ~rd_data);
      rda         <= 1'b1;
    end else if (rd_data) begin
      rda     <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_receive.sv
// Scoreboard bench for spart_receive: frames are pushed as expected bytes when
// transmitted; a monitor pops and compares whenever a new byte is presented.
module tb_spart_receive;

  logic       clk = 1'b0;
  logic       rst;
  logic       brg_tick;
  logic       rxd;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;

  // expected entry: {data[7:0], framing_err, overrun}
  logic [9:0] exp_q[$];
  logic [9:0] e;

  logic [1:0] div       = '0;
  logic       last_tick = 1'b0;
  logic       prev_rda  = 1'b0;
  logic [7:0] prev_data = '0;

  spart_receive #(.OVERSAMPLE(16), .DATA_BITS(8), .IDLE_LVL(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .brg_tick    (brg_tick),
    .rxd         (rxd),
    .iocs        (iocs),
    .iorw        (iorw),
    .ioaddr      (ioaddr),
    .rx_data     (rx_data),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun     (overrun),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  // brg_tick: one clk in every four
  always @(negedge clk) div <= div + 2'd1;
  assign brg_tick = (div == 2'd3);

  always @(posedge clk) last_tick <= brg_tick;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a new byte is rda rising, or rx_data replaced while rda stays high.
  always @(negedge clk) begin
    if (rst === 1'b0 && rda === 1'b1 && (prev_rda !== 1'b1 || rx_data !== prev_data)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte: got %0h expected none at %0t", rx_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("rx_data", {24'd0, rx_data}, {24'd0, e[9:2]});
        chk("framing_err", {31'd0, framing_err}, {31'd0, e[1]});
        chk("overrun", {31'd0, overrun}, {31'd0, e[0]});
        chk("rda_latency", {31'd0, last_tick}, 32'd1);
      end
    end
    prev_rda  <= rda;
    prev_data <= rx_data;
  end

  task automatic wait_tick();
    do @(posedge clk); while (brg_tick !== 1'b1);
  endtask

  // Aligns to a tick, then sends start, 8 data bits LSB first, stop (16 ticks each).
  task automatic tx_frame(input logic [7:0] d, input logic stop_lvl, input logic exp_ov);
    wait_tick();
    exp_q.push_back({d, ~stop_lvl, exp_ov});
    #1 rxd = 1'b0;
    repeat (16) wait_tick();
    for (int i = 0; i < 8; i++) begin
      #1 rxd = d[i];
      repeat (16) wait_tick();
    end
    #1 rxd = stop_lvl;
    repeat (16) wait_tick();
  endtask

  task automatic bus_read(input logic [1:0] a, input logic rw);
    @(posedge clk);
    #1 iocs = 1'b1; iorw = rw; ioaddr = a;
    @(posedge clk);
    #1 iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rxd = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rda", {31'd0, rda}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_fe", {31'd0, framing_err}, 32'd0);
    chk("rst_ov", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);

    // plain frame
    tx_frame(8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    chk("a5_rda", {31'd0, rda}, 32'd1);
    bus_read(2'd0, 1'b1);
    @(negedge clk);
    chk("a5_read_clears_rda", {31'd0, rda}, 32'd0);
    chk("a5_data_kept", {24'd0, rx_data}, 32'h0000_00a5);

    // false start: 6-tick low pulse
    wait_tick();
    #1 rxd = 1'b0;
    repeat (3) wait_tick();
    @(negedge clk);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd1);
    repeat (3) wait_tick();
    #1 rxd = 1'b1;
    repeat (12) wait_tick();
    @(negedge clk);
    chk("glitch_idle", {31'd0, rx_busy}, 32'd0);
    chk("glitch_rda", {31'd0, rda}, 32'd0);
    chk("glitch_fe", {31'd0, framing_err}, 32'd0);

    // framing error followed by break
    tx_frame(8'h3C, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      repeat (50) @(posedge clk);
      @(negedge clk);
      chk("break_hold_busy", {31'd0, rx_busy}, 32'd0);
    end
    chk("break_fe", {31'd0, framing_err}, 32'd1);
    @(posedge clk); #1 rxd = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("break_release_busy", {31'd0, rx_busy}, 32'd0);
    bus_read(2'd0, 1'b1);

    // overrun
    tx_frame(8'h11, 1'b1, 1'b0);
    tx_frame(8'h22, 1'b1, 1'b1);
    @(negedge clk);
    chk("ovr_rda", {31'd0, rda}, 32'd1);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    bus_read(2'd1, 1'b1);
    bus_read(2'd0, 1'b0);
    @(negedge clk);
    chk("ignored_rda", {31'd0, rda}, 32'd1);
    chk("ignored_ov", {31'd0, overrun}, 32'd1);
    bus_read(2'd0, 1'b1);
    @(negedge clk);
    chk("ovr_read_rda", {31'd0, rda}, 32'd0);
    chk("ovr_read_ov", {31'd0, overrun}, 32'd0);
    chk("ovr_data_kept", {24'd0, rx_data}, 32'h0000_0022);

    // read coinciding with completion: 152nd tick after the aligning tick
    tx_frame(8'h55, 1'b1, 1'b0);
    fork
      tx_frame(8'h7E, 1'b1, 1'b0);
      begin
        wait_tick();
        repeat (151) wait_tick();
        repeat (3) @(posedge clk);
        #1 iocs = 1'b1; iorw = 1'b1; ioaddr = 2'd0;
        @(posedge clk);
        #1 iocs = 1'b0; iorw = 1'b0;
      end
    join
    @(negedge clk);
    chk("same_clk_rda", {31'd0, rda}, 32'd1);
    chk("same_clk_ov", {31'd0, overrun}, 32'd0);
    chk("same_clk_data", {24'd0, rx_data}, 32'h0000_007e);

    // reset mid-frame after bit 3
    wait_tick();
    #1 rxd = 1'b0;
    repeat (16) wait_tick();
    for (int i = 0; i < 4; i++) begin
      #1 rxd = 1'b1;
      repeat (16) wait_tick();
    end
    @(posedge clk); #1 rst = 1'b1; rxd = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_rda", {31'd0, rda}, 32'd0);
    chk("midrst_data", {24'd0, rx_data}, 32'd0);
    chk("midrst_busy", {31'd0, rx_busy}, 32'd0);
    chk("midrst_fe_ov", {30'd0, framing_err, overrun}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    tx_frame(8'h81, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_rst_rda", {31'd0, rda}, 32'd1);

    repeat (20) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
